// File: rtl/bc_pkg.sv
// Shared encodings for the polynomial control block (bc).
// State codes, datapath mux selects and ULA op codes.
package bc_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CARREGA = 4'd1,
        P1      = 4'd2,
        P2      = 4'd3,
        P3      = 4'd4,
        P4      = 4'd5,
        P5      = 4'd6,
        Q1      = 4'd7,
        Q2      = 4'd8,
        Q3      = 4'd9,
        Q4      = 4'd10,
        FIM     = 4'd11
    } state_t;

    // M0: constant mux
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_A    = 2'd1;
    localparam logic [1:0] SEL_B    = 2'd2;
    localparam logic [1:0] SEL_C    = 2'd3;

    // M1: ULA operand 1
    localparam logic [1:0] SEL_X    = 2'd0;
    localparam logic [1:0] SEL_M0   = 2'd1;
    localparam logic [1:0] SEL_L    = 2'd2;
    localparam logic [1:0] SEL_H    = 2'd3;

    // M2: ULA operand 2 swaps the x / M0 codes
    localparam logic [1:0] SEL2_M0  = 2'd0;
    localparam logic [1:0] SEL2_X   = 2'd1;

    localparam logic H_SOMA = 1'b0;
    localparam logic H_MULT = 1'b1;

endpackage

// File: rtl/bc.sv
// Moore control FSM sequencing A*x^2 + B*x + C on the datapath.
// Define BC_HORNER_EN for the 4-step Horner sequence.
module bc
    import bc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       inicio,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       load_x,
    output logic       load_l,
    output logic       load_h,
    output logic       h,
    output logic       pronto,
    output logic       ocupado
);

    state_t state_q;
    state_t state_d;

    // State register, async active-low reset to IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and per-state control vector
    always_comb begin
        state_d = IDLE;
        M0      = SEL_ZERO;
        M1      = 2'd0;
        M2      = 2'd0;
        load_x  = 1'b0;
        load_l  = 1'b0;
        load_h  = 1'b0;
        h       = H_SOMA;
        pronto  = 1'b0;
        ocupado = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = inicio ? CARREGA : IDLE;
            end
            CARREGA: begin
                load_x  = 1'b1;
                ocupado = 1'b1;
`ifdef BC_HORNER_EN
                state_d = Q1;
`else
                state_d = P1;
`endif
            end
`ifdef BC_HORNER_EN
            Q1: begin
                M0      = SEL_A;
                M1      = SEL_M0;
                M2      = SEL2_X;
                h       = H_MULT;
                load_l  = 1'b1;
                ocupado = 1'b1;
                state_d = Q2;
            end
            Q2: begin
                M0      = SEL_B;
                M1      = SEL_L;
                M2      = SEL2_M0;
                h       = H_SOMA;
                load_l  = 1'b1;
                ocupado = 1'b1;
                state_d = Q3;
            end
            Q3: begin
                M1      = SEL_L;
                M2      = SEL2_X;
                h       = H_MULT;
                load_l  = 1'b1;
                ocupado = 1'b1;
                state_d = Q4;
            end
            Q4: begin
                M0      = SEL_C;
                M1      = SEL_L;
                M2      = SEL2_M0;
                h       = H_SOMA;
                load_l  = 1'b1;
                ocupado = 1'b1;
                state_d = FIM;
            end
`else
            P1: begin
                M0      = SEL_A;
                M1      = SEL_M0;
                M2      = SEL2_X;
                h       = H_MULT;
                load_l  = 1'b1;
                ocupado = 1'b1;
                state_d = P2;
            end
            P2: begin
                M1      = SEL_L;
                M2      = SEL2_X;
                h       = H_MULT;
                load_l  = 1'b1;
                ocupado = 1'b1;
                state_d = P3;
            end
            P3: begin
                M0      = SEL_B;
                M1      = SEL_M0;
                M2      = SEL2_X;
                h       = H_MULT;
                load_h  = 1'b1;
                ocupado = 1'b1;
                state_d = P4;
            end
            P4: begin
                M1      = SEL_L;
                M2      = SEL_H;
                h       = H_SOMA;
                load_l  = 1'b1;
                ocupado = 1'b1;
                state_d = P5;
            end
            P5: begin
                M0      = SEL_C;
                M1      = SEL_L;
                M2      = SEL2_M0;
                h       = H_SOMA;
                load_l  = 1'b1;
                ocupado = 1'b1;
                state_d = FIM;
            end
`endif
            FIM: begin
                pronto  = 1'b1;
                state_d = inicio ? CARREGA : FIM;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bc.sv
// Directed bench for bc with a behavioural polynomial datapath.
// Table of per-state control vectors plus multi-cycle sequences.
module tb_bc;
    import bc_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       inicio = 1'b0;
    logic [1:0] M0, M1, M2;
    logic       load_x, load_l, load_h, h, pronto, ocupado;

    bc dut (
        .clock   (clock),
        .reset   (reset),
        .inicio  (inicio),
        .M0      (M0),
        .M1      (M1),
        .M2      (M2),
        .load_x  (load_x),
        .load_l  (load_l),
        .load_h  (load_h),
        .h       (h),
        .pronto  (pronto),
        .ocupado (ocupado)
    );

    always #5 clock = ~clock;

`ifdef BC_HORNER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 7;
`endif

    // behavioural datapath
    logic [15:0] a_in = 16'd0, b_in = 16'd0, c_in = 16'd0;
    logic [7:0]  x_in = 8'd0;
    logic [7:0]  x_q;
    logic [15:0] l_q, h_q, m0_out, op1, op2, ula, resultado;

    always_comb begin
        m0_out = 16'd0;
        case (M0)
            2'd1: m0_out = a_in;
            2'd2: m0_out = b_in;
            2'd3: m0_out = c_in;
            default: m0_out = 16'd0;
        endcase
        op1 = 16'd0;
        case (M1)
            2'd0: op1 = {8'd0, x_q};
            2'd1: op1 = m0_out;
            2'd2: op1 = l_q;
            default: op1 = h_q;
        endcase
        op2 = 16'd0;
        case (M2)
            2'd0: op2 = m0_out;
            2'd1: op2 = {8'd0, x_q};
            2'd2: op2 = l_q;
            default: op2 = h_q;
        endcase
        ula = h ? 16'(op1 * op2) : 16'(op1 + op2);
        resultado = pronto ? l_q : 16'd0;
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q <= 8'd0;
            l_q <= 16'd0;
            h_q <= 16'd0;
        end else begin
            if (load_x) x_q <= x_in;
            if (load_l) l_q <= ula;
            if (load_h) h_q <= ula;
        end
    end

    logic saw_h = 1'b0;
    always @(posedge clock) if (load_h) saw_h <= 1'b1;

    logic [11:0] ctl_w;
    assign ctl_w = {M0, M1, M2, load_x, load_l, load_h, h, pronto, ocupado};

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0] mk(input int m0, input int m1,
        input int m2, input bit lx, input bit ll, input bit lh,
        input bit hh, input bit pr, input bit oc);
        return {m0[1:0], m1[1:0], m2[1:0], lx, ll, lh, hh, pr, oc};
    endfunction

    typedef struct {
        logic        ini;
        logic [11:0] ctl;
    } vec_t;

    vec_t tbl [0:7];
    int   ntbl;

    task automatic run_calc(input string nm, input logic [15:0] a,
        input logic [15:0] b, input logic [15:0] c, input logic [7:0] xv,
        input logic [15:0] exp_res);
        int n;
        int occ;
        a_in = a; b_in = b; c_in = c; x_in = xv;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        check({nm, "_pronto_low"}, {31'd0, pronto}, 32'd0);
        n = 1;
        occ = ocupado ? 1 : 0;
        while (!pronto && n < 20) begin
            step();
            n++;
            if (ocupado) occ++;
        end
        check({nm, "_lat"}, n, LAT);
        check({nm, "_ocupado"}, occ, LAT - 1);
        check({nm, "_res"}, {16'd0, resultado}, {16'd0, exp_res});
    endtask

    initial begin
        tbl[0] = '{1'b1, mk(0, 0, 0, 1, 0, 0, 0, 0, 1)};
`ifdef BC_HORNER_EN
        tbl[1] = '{1'b0, mk(1, 1, 1, 0, 1, 0, 1, 0, 1)};
        tbl[2] = '{1'b0, mk(2, 2, 0, 0, 1, 0, 0, 0, 1)};
        tbl[3] = '{1'b0, mk(0, 2, 1, 0, 1, 0, 1, 0, 1)};
        tbl[4] = '{1'b0, mk(3, 2, 0, 0, 1, 0, 0, 0, 1)};
        tbl[5] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[6] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[7] = '{1'b0, 12'd0};
        ntbl = 7;
`else
        tbl[1] = '{1'b0, mk(1, 1, 1, 0, 1, 0, 1, 0, 1)};
        tbl[2] = '{1'b0, mk(0, 2, 1, 0, 1, 0, 1, 0, 1)};
        tbl[3] = '{1'b0, mk(2, 1, 1, 0, 0, 1, 1, 0, 1)};
        tbl[4] = '{1'b0, mk(0, 2, 3, 0, 1, 0, 0, 0, 1)};
        tbl[5] = '{1'b0, mk(3, 2, 0, 0, 1, 0, 0, 0, 1)};
        tbl[6] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[7] = '{1'b0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        ntbl = 8;
`endif

        // reset state
        step();
        check("reset_ctl", {20'd0, ctl_w}, 32'd0);
        reset = 1'b1;
        step();
        step();
        check("idle_ctl", {20'd0, ctl_w}, 32'd0);

        // per-state control vectors, A=2 B=3 C=4 x=5
        a_in = 16'd2; b_in = 16'd3; c_in = 16'd4; x_in = 8'd5;
        for (int i = 0; i < ntbl; i++) begin
            inicio = tbl[i].ini;
            step();
            check($sformatf("vec%0d", i), {20'd0, ctl_w},
                  {20'd0, tbl[i].ctl});
            check($sformatf("onehot%0d", i),
                  {31'd0, $onehot0({load_x, load_l, load_h})}, 32'd1);
        end
        check("tbl_res", {16'd0, resultado}, 32'd69);

        // zero coefficients, then restart from FIM
        run_calc("c_only", 16'd0, 16'd0, 16'd7, 8'd9, 16'd7);
        run_calc("ones", 16'd1, 16'd1, 16'd1, 8'd1, 16'd3);

        // modulo 2^16 wrap
        run_calc("wrap", 16'h0100, 16'd0, 16'd0, 8'h10, 16'd0);

        // async reset in third compute state
        a_in = 16'd2; b_in = 16'd3; c_in = 16'd4; x_in = 8'd5;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        step();
        step();
        step();
        check("pre_rst_busy", {31'd0, ocupado}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", {20'd0, ctl_w}, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("post_rst_idle", {20'd0, ctl_w}, 32'd0);
        run_calc("after_rst", 16'd2, 16'd3, 16'd4, 8'd5, 16'd69);

        // inicio held high: no restart until FIM
        a_in = 16'd2; b_in = 16'd3; c_in = 16'd4; x_in = 8'd5;
        for (int i = 0; i < ntbl - 1; i++) begin
            inicio = 1'b1;
            step();
            check($sformatf("hold%0d", i), {20'd0, ctl_w},
                  {20'd0, tbl[i].ctl});
        end
        check("hold_res", {16'd0, resultado}, 32'd69);
        step();
        check("hold_restart", {20'd0, ctl_w}, {20'd0, tbl[0].ctl});
        inicio = 1'b0;
        for (int i = 0; i < 10 && !pronto; i++) step();
        check("hold_done", {16'd0, resultado}, 32'd69);

`ifdef BC_HORNER_EN
        check("load_h_seen", {31'd0, saw_h}, 32'd0);
`else
        check("load_h_seen", {31'd0, saw_h}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
